rv32_regfile: RTL and testbench
===============================

Name: rv32_regfile

Overview:
- Integer register file for the RV32I single-cycle core.
- Supplies operand values rv1/rv2 to the R-type, I-type and B-type execute blocks, and accepts the write-back result (regdata) from them. It is the source and sink at the opposite end of the execute-unit interface.
- Also exposes x31 for bench observation, and a committed-write counter for debug.

Parameters:
- XLEN, 32, register width in bits.
- SP_RESET, 32'h0000_3FFC, reset value of x2 (stack pointer).
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rs1  input  5  read address, port 1 (idata[19:15]).
- rs2  input  5  read address, port 2 (idata[24:20]).
- rv1  output  XLEN  read data, port 1.
- rv2  output  XLEN  read data, port 2.
- we  input  1  write enable from write-back select.
- rd  input  5  write address (idata[11:7]).
- wdata  input  XLEN  write-back data.
- x31  output  XLEN  current stored contents of x31 (debug/bench).
- wr_count  output  32  number of committed writes to x1..x31 since reset.

Behaviour:
- Storage: 31 physical XLEN-bit registers x1..x31. x0 is not stored and always reads 0.
- Reset: on a rising edge with reset=1:
  - all registers clear to 0, except x2, which loads SP_RESET;
  - wr_count clears to 0.
  - Reset has priority over a simultaneous write; a write presented that cycle is dropped and not counted.
- Reset values seen one cycle after the edge: rv1/rv2 = 0 for any address except 2, which reads SP_RESET; x31 = 0; wr_count = 0.
- Write:
  - On a rising edge with reset=0, we=1 and rd!=0: reg[rd] <= wdata and wr_count <= wr_count+1.
  - we=1 with rd=0 is discarded: no state change, no count.
  - we=0: no change.
- Read: combinational, zero latency. rvN = 0 if rsN==0; otherwise reg[rsN].
- Bypass:
  - BYPASS=1: if we=1, rd!=0 and rd==rsN, then rvN = wdata in the same cycle, before the edge.
  - BYPASS=0: rvN shows the old value until the edge.
  - Bypass is suppressed while reset=1. rv1/rv2 then show stored values, with the same rules as the normal read.
- Both ports may address the same register, and each gets an identical value. Both may match rd, and both are bypassed.
- x31 port: always reflects stored reg[31]. No bypass. It updates the cycle after the write edge.
- wr_count: a 32-bit wrapping counter. 32'hFFFF_FFFF + 1 -> 0, with no flag.
- Reset mid-operation: pending write data is lost. Registers and counter return to reset values on that edge regardless of we.
- No X propagation: stored regs are never uninitialised after the first reset edge.

Test Plan:
- Reset: assert reset 2 cycles, release; rs1=2, rs2=5 -> rv1=32'h0000_3FFC, rv2=0, x31=0, wr_count=0.
- Write/read:
  - we=1, rd=7, wdata=415, then rd=8, wdata=60, on consecutive edges, then we=0;
  - rs1=7, rs2=8 -> rv1=415, rv2=60, wr_count=2.
  - Feeding rv1/rv2 into R-type ADD gives regdata=475.
- x0 hardwire: we=1, rd=0, wdata=32'hDEAD_BEEF; then rs1=0 -> rv1=0, and wr_count unchanged.
- Bypass (BYPASS=1):
  - reg x9=100; same cycle present we=1, rd=9, wdata=6553, rs1=9, rs2=9;
  - before the edge, rv1=rv2=6553.
  - With BYPASS=0, same stimulus: rv1=rv2=100 before the edge, 6553 after.
- x31 and reset priority:
  - write x31=32'h8000_0000 -> x31 port shows it one cycle after the edge, not before.
  - Then, in one cycle, reset=1 with we=1, rd=31, wdata=5 -> x31=0 and wr_count=0 after the edge.
- Counter wrap: preload via 2^32-1 writes (or force in sim), then one write to x3 -> wr_count=0, and x3 holds the written value.

Source files
------------

// File: rtl/rv32_regfile.sv
`default_nettype none
// ============================================================================
// Module   : rv32_regfile
// Brief    : RV32I integer register file. It has two combinational read ports
//            with optional same-cycle write forwarding, one write port, a
//            debug view of x31, and a counter of committed writes.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_regfile #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      SP_RESET = 32'h0000_3FFC,
  parameter bit                   BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  input  logic            we,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] x31,
  output logic [31:0]     wr_count
);

  localparam logic [4:0]      c_REG_SP = 5'd2;
  localparam logic [XLEN-1:0] c_ZERO   = '0;

  // Only x1..x31 are physically stored. x0 is synthesised as a constant zero.
  logic [XLEN-1:0] r_regs [1:31];
  logic [31:0]     r_wr_count;

  // A write commits only when it is enabled, targets a real register, and is
  // not overridden by reset.
  logic w_wr_commit;
  assign w_wr_commit = we && (rd != 5'd0) && !reset;

  // Register array update. Reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= (5'(i) == c_REG_SP) ? SP_RESET : c_ZERO;
      end
    end else if (w_wr_commit) begin
      r_regs[rd] <= wdata;
    end
  end

  // Committed-write counter. It wraps silently at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_count <= 32'd0;
    end else if (w_wr_commit) begin
      r_wr_count <= r_wr_count + 32'd1;
    end
  end

  // Stored-value reads. Address 0 always reads zero.
  logic [XLEN-1:0] w_rd1_stored;
  logic [XLEN-1:0] w_rd2_stored;

  // Combinational lookup of stored contents for both read ports.
  always_comb begin
    w_rd1_stored = c_ZERO;
    w_rd2_stored = c_ZERO;
    if (rs1 != 5'd0) w_rd1_stored = r_regs[rs1];
    if (rs2 != 5'd0) w_rd2_stored = r_regs[rs2];
  end

  // Forwarding uses the commit qualifier, so it is automatically disabled
  // during reset and for writes to x0.
  generate
    if (BYPASS) begin : g_bypass
      logic w_fwd1;
      logic w_fwd2;
      assign w_fwd1 = w_wr_commit && (rd == rs1);
      assign w_fwd2 = w_wr_commit && (rd == rs2);
      assign rv1    = w_fwd1 ? wdata : w_rd1_stored;
      assign rv2    = w_fwd2 ? wdata : w_rd2_stored;
    end else begin : g_no_bypass
      assign rv1 = w_rd1_stored;
      assign rv2 = w_rd2_stored;
    end
  endgenerate

  assign x31      = r_regs[31];
  assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_rv32_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_regfile
// Brief    : Directed self-checking bench for rv32_regfile. It drives one
//            instance with forwarding enabled and one with it disabled, in
//            parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_regfile;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] SP   = 32'h0000_3FFC;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      rs1, rs2, rd;
  logic            we;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rv1, rv2, x31;
  logic [31:0]     wr_count;
  logic [XLEN-1:0] rv1_nb, rv2_nb, x31_nb;
  logic [31:0]     wr_count_nb;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rv32_regfile #(.XLEN(XLEN), .SP_RESET(SP), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rv1(rv1), .rv2(rv2),
    .we(we), .rd(rd), .wdata(wdata), .x31(x31), .wr_count(wr_count)
  );

  rv32_regfile #(.XLEN(XLEN), .SP_RESET(SP), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rv1(rv1_nb), .rv2(rv2_nb),
    .we(we), .rd(rd), .wdata(wdata), .x31(x31_nb), .wr_count(wr_count_nb)
  );

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; we = 1'b0; rd = 5'd0; wdata = '0; rs1 = 5'd0; rs2 = 5'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; rs1 = 5'd2; rs2 = 5'd5;
    #1;
    vectors++; if (rv1 !== SP) begin errors++; $display("FAIL reset_rv1 got %h exp %h", rv1, SP); end
    vectors++; if (rv2 !== 32'd0) begin errors++; $display("FAIL reset_rv2 got %h exp 0", rv2); end
    vectors++; if (x31 !== 32'd0) begin errors++; $display("FAIL reset_x31 got %h exp 0", x31); end
    vectors++; if (wr_count !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h exp 0", wr_count); end
    vectors++; if (rv1_nb !== SP) begin errors++; $display("FAIL reset_rv1_nb got %h exp %h", rv1_nb, SP); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we = 1'b1; rd = 5'd7; wdata = 32'd415;
    @(negedge clk);
    rd = 5'd8; wdata = 32'd60;
    @(negedge clk);
    we = 1'b0; rs1 = 5'd7; rs2 = 5'd8;
    #1;
    vectors++; if (rv1 !== 32'd415) begin errors++; $display("FAIL wr_rv1 got %0d exp 415", rv1); end
    vectors++; if (rv2 !== 32'd60) begin errors++; $display("FAIL wr_rv2 got %0d exp 60", rv2); end
    vectors++; if (wr_count !== 32'd2) begin errors++; $display("FAIL wr_cnt got %0d exp 2", wr_count); end
    vectors++; if (rv1 + rv2 !== 32'd475) begin errors++; $display("FAIL wr_add got %0d exp 475", rv1 + rv2); end
    // Same register on both ports.
    rs2 = 5'd7;
    #1;
    vectors++; if (rv2 !== 32'd415) begin errors++; $display("FAIL wr_same got %0d exp 415", rv2); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    we = 1'b1; rd = 5'd0; wdata = 32'hDEAD_BEEF; rs1 = 5'd0;
    #1;
    vectors++; if (rv1 !== 32'd0) begin errors++; $display("FAIL x0_fwd got %h exp 0", rv1); end
    @(negedge clk);
    we = 1'b0;
    #1;
    vectors++; if (rv1 !== 32'd0) begin errors++; $display("FAIL x0_read got %h exp 0", rv1); end
    vectors++; if (wr_count !== 32'd2) begin errors++; $display("FAIL x0_cnt got %0d exp 2", wr_count); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we = 1'b1; rd = 5'd9; wdata = 32'd100;
    @(negedge clk);
    wdata = 32'd6553; rs1 = 5'd9; rs2 = 5'd9;
    #1;
    vectors++; if (rv1 !== 32'd6553) begin errors++; $display("FAIL byp_rv1 got %0d exp 6553", rv1); end
    vectors++; if (rv2 !== 32'd6553) begin errors++; $display("FAIL byp_rv2 got %0d exp 6553", rv2); end
    vectors++; if (rv1_nb !== 32'd100) begin errors++; $display("FAIL nobyp_rv1 got %0d exp 100", rv1_nb); end
    vectors++; if (rv2_nb !== 32'd100) begin errors++; $display("FAIL nobyp_rv2 got %0d exp 100", rv2_nb); end
    @(negedge clk);
    // Forward on port 2 only. Port 1 reads stored x9.
    rd = 5'd7; wdata = 32'd77; rs1 = 5'd9; rs2 = 5'd7;
    #1;
    vectors++; if (rv1_nb !== 32'd6553) begin errors++; $display("FAIL nobyp_after got %0d exp 6553", rv1_nb); end
    vectors++; if (rv1 !== 32'd6553) begin errors++; $display("FAIL byp_p1_stored got %0d exp 6553", rv1); end
    vectors++; if (rv2 !== 32'd77) begin errors++; $display("FAIL byp_p2 got %0d exp 77", rv2); end
    vectors++; if (rv2_nb !== 32'd415) begin errors++; $display("FAIL nobyp_p2 got %0d exp 415", rv2_nb); end
    @(negedge clk);
    we = 1'b0;
    #1;
    vectors++; if (wr_count !== 32'd5) begin errors++; $display("FAIL byp_cnt got %0d exp 5", wr_count); end
  endtask

  task automatic test_x31_reset_priority();
    @(negedge clk);
    we = 1'b1; rd = 5'd31; wdata = 32'h8000_0000; rs1 = 5'd31;
    #1;
    vectors++; if (x31 !== 32'd0) begin errors++; $display("FAIL x31_early got %h exp 0", x31); end
    vectors++; if (rv1 !== 32'h8000_0000) begin errors++; $display("FAIL x31_fwd got %h exp 80000000", rv1); end
    @(posedge clk);
    #1;
    vectors++; if (x31 !== 32'h8000_0000) begin errors++; $display("FAIL x31_after got %h exp 80000000", x31); end
    @(negedge clk);
    reset = 1'b1; we = 1'b1; rd = 5'd31; wdata = 32'd5; rs1 = 5'd31;
    #1;
    vectors++; if (rv1 !== 32'h8000_0000) begin errors++; $display("FAIL rst_nofwd got %h exp 80000000", rv1); end
    @(posedge clk);
    #1;
    vectors++; if (x31 !== 32'd0) begin errors++; $display("FAIL rst_x31 got %h exp 0", x31); end
    vectors++; if (wr_count !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", wr_count); end
    @(negedge clk);
    reset = 1'b0; we = 1'b0; rs1 = 5'd7; rs2 = 5'd2;
    #1;
    vectors++; if (rv1 !== 32'd0) begin errors++; $display("FAIL rst_x7 got %0d exp 0", rv1); end
    vectors++; if (rv2 !== SP) begin errors++; $display("FAIL rst_sp got %h exp %h", rv2, SP); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.r_wr_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_wr_count;
    #1;
    vectors++; if (wr_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffffffff", wr_count); end
    @(negedge clk);
    we = 1'b1; rd = 5'd3; wdata = 32'h1234_5678;
    @(negedge clk);
    we = 1'b0; rs1 = 5'd3;
    #1;
    vectors++; if (wr_count !== 32'd0) begin errors++; $display("FAIL wrap_cnt got %h exp 0", wr_count); end
    vectors++; if (rv1 !== 32'h1234_5678) begin errors++; $display("FAIL wrap_x3 got %h exp 12345678", rv1); end
    vectors++; if (wr_count_nb !== 32'd1) begin errors++; $display("FAIL wrap_cnt_nb got %0d exp 1", wr_count_nb); end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; rd = 5'd0; wdata = '0; rs1 = 5'd0; rs2 = 5'd0;
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_x31_reset_priority();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
